// File: rtl/rob_dispatch_alloc_pkg.sv
// Shared ROB geometry and tag helpers; the ROB imports the same definitions so
// tag width and wrap behaviour stay consistent between dispatch and retire.
package rob_dispatch_alloc_pkg;
  localparam int ROB_NUM   = 16;
  localparam int ROB_SEL   = $clog2(ROB_NUM);
  localparam int TAG_W     = ROB_SEL + 1;
  localparam int PAYLOAD_W = 32;

  typedef logic [TAG_W-1:0]   rob_tag_t;
  typedef logic [ROB_SEL:0]   rob_cnt_t;
  typedef logic [ROB_SEL-1:0] rob_idx_t;

  // Tag arithmetic is mod 2*ROB_NUM, which the natural TAG_W-bit wrap provides.
  function automatic rob_tag_t rob_tag_inc(input rob_tag_t tag, input logic [1:0] n);
    return tag + rob_tag_t'(n);
  endfunction

  function automatic rob_idx_t rob_tag_idx(input rob_tag_t tag);
    return tag[ROB_SEL-1:0];
  endfunction
endpackage

// File: rtl/rob_occupancy_ctr.sv
// ROB occupancy tracker: count from dispatch/commit, combinational free for the
// ready logic, and a registered free_count view of the same value.
module rob_occupancy_ctr
  import rob_dispatch_alloc_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic [1:0] i_n_acc,
  input  logic [1:0] i_commit_count,
  input  logic     i_flush,
  output rob_cnt_t o_free,
  output rob_cnt_t o_free_count
);
  rob_cnt_t r_count;
  rob_cnt_t r_free_count;
  rob_cnt_t w_count_next;

  always_comb begin
    w_count_next = r_count + rob_cnt_t'(i_n_acc) - rob_cnt_t'(i_commit_count);
    // Flush mirrors the ROB emptying itself; pending commits are moot.
    if (i_flush) w_count_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_free_count <= rob_cnt_t'(ROB_NUM);
    end else begin
      r_count      <= w_count_next;
      r_free_count <= rob_cnt_t'(ROB_NUM) - w_count_next;
    end
  end

  // Ready uses the current count, so commit-freed slots show up one cycle later.
  assign o_free       = rob_cnt_t'(ROB_NUM) - r_count;
  assign o_free_count = r_free_count;
endmodule

// File: rtl/rob_dispatch_alloc.sv
// 2-wide dispatch into the ROB: in-order tag allocation, slot compaction and a
// one-cycle registered dispatch/payload stage.
module rob_dispatch_alloc
  import rob_dispatch_alloc_pkg::*;
#(
  parameter int PW = PAYLOAD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_1,
  input  logic          in_valid_2,
  input  logic [PW-1:0] in_payload_1,
  input  logic [PW-1:0] in_payload_2,
  output logic          in_ready_1,
  output logic          in_ready_2,
  input  logic [1:0]    commit_count,
  input  logic          flush,
  output logic          dispatch_rob_valid_1,
  output logic          dispatch_rob_valid_2,
  output rob_tag_t      rob_idx_out_1,
  output rob_tag_t      rob_idx_out_2,
  output logic [PW-1:0] out_payload_1,
  output logic [PW-1:0] out_payload_2,
  output rob_cnt_t      free_count
);
  rob_tag_t      r_tail;
  logic          r_vld_1, r_vld_2;
  rob_tag_t      r_tag_1, r_tag_2;
  logic [PW-1:0] r_pl_1, r_pl_2;

  rob_cnt_t      w_free;
  logic          w_rdy_1, w_rdy_2;
  logic          w_acc_1, w_acc_2;
  logic [1:0]    w_n_acc;

  rob_occupancy_ctr u_occ (
    .clk            (clk),
    .reset          (reset),
    .i_n_acc        (w_n_acc),
    .i_commit_count (commit_count),
    .i_flush        (flush),
    .o_free         (w_free),
    .o_free_count   (free_count)
  );

  // Ready is independent of in_valid_2; slot 2 may use the last entry only if
  // slot 1 is not competing for it.
  always_comb begin
    w_rdy_1 = !flush && (w_free != '0);
    w_rdy_2 = !flush && ((w_free >= rob_cnt_t'(2)) || ((w_free != '0) && !in_valid_1));
    w_acc_1 = in_valid_1 && w_rdy_1;
    w_acc_2 = in_valid_2 && w_rdy_2 && (w_acc_1 || !in_valid_1);
    w_n_acc = {1'b0, w_acc_1} + {1'b0, w_acc_2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tail <= '0;
    end else if (flush) begin
      r_tail <= '0;
    end else begin
      r_tail <= rob_tag_inc(r_tail, w_n_acc);
    end
  end

  // Output stage is rewritten every cycle; accepted work packs into slot 1 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_1 <= 1'b0;
      r_vld_2 <= 1'b0;
      r_tag_1 <= '0;
      r_tag_2 <= '0;
      r_pl_1  <= '0;
      r_pl_2  <= '0;
    end else begin
      r_vld_1 <= w_acc_1 || w_acc_2;
      r_vld_2 <= w_acc_1 && w_acc_2;
      r_tag_1 <= r_tail;
      r_tag_2 <= rob_tag_inc(r_tail, 2'd1);
      r_pl_1  <= w_acc_1 ? in_payload_1 : in_payload_2;
      r_pl_2  <= in_payload_2;
    end
  end

  assign in_ready_1           = w_rdy_1;
  assign in_ready_2           = w_rdy_2;
  assign dispatch_rob_valid_1 = r_vld_1;
  assign dispatch_rob_valid_2 = r_vld_2;
  assign rob_idx_out_1        = r_tag_1;
  assign rob_idx_out_2        = r_tag_2;
  assign out_payload_1        = r_pl_1;
  assign out_payload_2        = r_pl_2;
endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Directed bench for rob_dispatch_alloc: fill, full/one-free, slot-2-only,
// commit+dispatch wrap, flush and async reset.
module tb_rob_dispatch_alloc;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_payload_1, in_payload_2;
  logic        in_ready_1, in_ready_2;
  logic [1:0]  commit_count;
  logic        flush;
  logic        dispatch_rob_valid_1, dispatch_rob_valid_2;
  logic [4:0]  rob_idx_out_1, rob_idx_out_2;
  logic [31:0] out_payload_1, out_payload_2;
  logic [4:0]  free_count;

  int n_chk = 0;
  int n_err = 0;

  rob_dispatch_alloc dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid_1           (in_valid_1),
    .in_valid_2           (in_valid_2),
    .in_payload_1         (in_payload_1),
    .in_payload_2         (in_payload_2),
    .in_ready_1           (in_ready_1),
    .in_ready_2           (in_ready_2),
    .commit_count         (commit_count),
    .flush                (flush),
    .dispatch_rob_valid_1 (dispatch_rob_valid_1),
    .dispatch_rob_valid_2 (dispatch_rob_valid_2),
    .rob_idx_out_1        (rob_idx_out_1),
    .rob_idx_out_2        (rob_idx_out_2),
    .out_payload_1        (out_payload_1),
    .out_payload_2        (out_payload_2),
    .free_count           (free_count)
  );

  always #5 clk = ~clk;

  // Stimulus legality: never retire more than is occupied, never 3.
  always @(posedge clk) begin
    if (!reset) begin
      assert (commit_count != 2'd3);
      assert (32'(commit_count) <= 32'd16 - 32'(free_count));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; commit_count = 2'd0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_payload_1 = '0; in_payload_2 = '0;
    #12;
    chk("rst_v1", 64'(dispatch_rob_valid_1), 64'(0));
    chk("rst_v2", 64'(dispatch_rob_valid_2), 64'(0));
    chk("rst_tag1", 64'(rob_idx_out_1), 64'(0));
    chk("rst_pl1", 64'(out_payload_1), 64'(0));
    chk("rst_free", 64'(free_count), 64'(16));
    reset = 1'b0;

    // Fill: both slots every cycle, tags (0,1)..(14,15).
    in_valid_1 = 1'b1; in_valid_2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_payload_1 = 32'h1000 + 32'(2*i);
      in_payload_2 = 32'h1000 + 32'(2*i+1);
      #1;
      chk("fill_rdy1", 64'(in_ready_1), 64'(1));
      chk("fill_rdy2", 64'(in_ready_2), 64'(1));
      tick();
      chk("fill_v1", 64'(dispatch_rob_valid_1), 64'(1));
      chk("fill_v2", 64'(dispatch_rob_valid_2), 64'(1));
      chk("fill_tag1", 64'(rob_idx_out_1), 64'(2*i));
      chk("fill_tag2", 64'(rob_idx_out_2), 64'(2*i+1));
      chk("fill_pl1", 64'(out_payload_1), 64'(32'h1000 + 32'(2*i)));
      chk("fill_pl2", 64'(out_payload_2), 64'(32'h1000 + 32'(2*i+1)));
      chk("fill_free", 64'(free_count), 64'(14 - 2*i));
    end
    #1;
    chk("full_rdy1", 64'(in_ready_1), 64'(0));
    chk("full_rdy2", 64'(in_ready_2), 64'(0));
    chk("full_free", 64'(free_count), 64'(0));

    // One commit while full; visible to ready only the following cycle.
    commit_count = 2'd1;
    tick();
    chk("full_nov1", 64'(dispatch_rob_valid_1), 64'(0));
    chk("one_free", 64'(free_count), 64'(1));
    commit_count = 2'd0;
    in_payload_1 = 32'hAA; in_payload_2 = 32'hBB;
    #1;
    chk("one_rdy1", 64'(in_ready_1), 64'(1));
    chk("one_rdy2", 64'(in_ready_2), 64'(0));
    tick();
    chk("one_v1", 64'(dispatch_rob_valid_1), 64'(1));
    chk("one_v2", 64'(dispatch_rob_valid_2), 64'(0));
    chk("one_tag1", 64'(rob_idx_out_1), 64'(16));
    chk("one_pl1", 64'(out_payload_1), 64'(32'hAA));
    chk("one_free0", 64'(free_count), 64'(0));

    // Drain to free=5, then present slot 2 alone.
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    commit_count = 2'd2; tick(); tick();
    commit_count = 2'd1; tick();
    commit_count = 2'd0;
    chk("drain_free", 64'(free_count), 64'(5));
    in_valid_2 = 1'b1; in_payload_2 = 32'hCC;
    #1;
    chk("s2_rdy2", 64'(in_ready_2), 64'(1));
    tick();
    chk("s2_v1", 64'(dispatch_rob_valid_1), 64'(1));
    chk("s2_v2", 64'(dispatch_rob_valid_2), 64'(0));
    chk("s2_tag1", 64'(rob_idx_out_1), 64'(17));
    chk("s2_pl1", 64'(out_payload_1), 64'(32'hCC));
    chk("s2_free", 64'(free_count), 64'(4));

    // Flush beats accept and commit in the same cycle.
    in_valid_1 = 1'b1; in_valid_2 = 1'b1;
    commit_count = 2'd1; flush = 1'b1;
    #1;
    chk("fl_rdy1", 64'(in_ready_1), 64'(0));
    chk("fl_rdy2", 64'(in_ready_2), 64'(0));
    tick();
    flush = 1'b0; commit_count = 2'd0;
    chk("fl_v1", 64'(dispatch_rob_valid_1), 64'(0));
    chk("fl_v2", 64'(dispatch_rob_valid_2), 64'(0));
    chk("fl_free", 64'(free_count), 64'(16));

    // Refill to count=14 from tag 0.
    for (int i = 0; i < 7; i++) begin
      in_payload_1 = 32'h2000 + 32'(2*i);
      in_payload_2 = 32'h2000 + 32'(2*i+1);
      tick();
      chk("rf_tag1", 64'(rob_idx_out_1), 64'(2*i));
      chk("rf_tag2", 64'(rob_idx_out_2), 64'(2*i+1));
    end
    chk("rf_free", 64'(free_count), 64'(2));

    // Dispatch two while committing two: count holds at 14, tags wrap.
    commit_count = 2'd2;
    #1;
    chk("cd_rdy1", 64'(in_ready_1), 64'(1));
    chk("cd_rdy2", 64'(in_ready_2), 64'(1));
    tick();
    chk("cd_tag1", 64'(rob_idx_out_1), 64'(14));
    chk("cd_tag2", 64'(rob_idx_out_2), 64'(15));
    chk("cd_free", 64'(free_count), 64'(2));
    tick();
    chk("wr_v2", 64'(dispatch_rob_valid_2), 64'(1));
    chk("wr_tag1", 64'(rob_idx_out_1), 64'(16));
    chk("wr_tag2", 64'(rob_idx_out_2), 64'(17));
    chk("wr_free", 64'(free_count), 64'(2));

    // Async reset pulse between edges, mid-stream.
    commit_count = 2'd0;
    tick();
    chk("ms_tag1", 64'(rob_idx_out_1), 64'(18));
    #2 reset = 1'b1;
    #1;
    chk("ar_v1", 64'(dispatch_rob_valid_1), 64'(0));
    chk("ar_v2", 64'(dispatch_rob_valid_2), 64'(0));
    chk("ar_tag1", 64'(rob_idx_out_1), 64'(0));
    chk("ar_free", 64'(free_count), 64'(16));
    reset = 1'b0;
    tick();
    chk("pr_v2", 64'(dispatch_rob_valid_2), 64'(1));
    chk("pr_tag1", 64'(rob_idx_out_1), 64'(0));
    chk("pr_tag2", 64'(rob_idx_out_2), 64'(1));
    chk("pr_free", 64'(free_count), 64'(14));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
